// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the ALU execution path: the 4-bit alu_ctrl codes
//   (also used by the ALU control decoder) and the execution FSM encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// -----------------------------------------------------------------------------
// alu_exec_unit_if
//   Request/response bundle of the ALU execution unit.
//   master : issues requests (in_valid, alu_ctrl, op_a, op_b) and accepts
//            results (out_ready); sees in_ready, out_valid, result and flags.
//   slave  : the execution unit itself.
// -----------------------------------------------------------------------------
interface alu_exec_unit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ALU_CODE_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      result;
  logic                  zero;
  logic                  ovf;
  logic                  err;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, err
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, ovf, err
  );

endinterface

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
//   Iterative shift-add multiplier, one partial product per clock, WIDTH
//   iterations. Only the low WIDTH bits of the product are kept.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        latch operands, clear accumulator, begin iterating
//   mcand_in     multiplicand
//   mplier_in    multiplier
//   busy         iterations in progress
//   done         high during the last iteration (combinational)
//   product      accumulator value after the current iteration; valid with done
// -----------------------------------------------------------------------------
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // done is flagged during the final iteration so the caller can capture
  // acc_next on the same edge that performs the last add.
  assign busy    = busy_reg;
  assign done    = busy_reg && (cnt_reg == LAST);
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= mcand_in;
      mplier_reg <= mplier_in;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (cnt_reg == LAST) begin
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execution end of the ALU control path. Accepts a decoded alu_ctrl code
//   with two operands under valid/ready, returns a registered result with
//   zero/overflow/error flags. Logic ops, ADD/SUB/SLT take one cycle; MUL
//   (when MUL_EN) uses the iterative multiplier and takes WIDTH cycles.
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of alu_exec_unit_if (request, response, flags)
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  state_t           state_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             ovf_reg;
  logic             err_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] nor_v;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_err;
  logic             is_mul;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // Bitwise ops, one slice per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign and_v[gi] = bus.op_a[gi] & bus.op_b[gi];
    assign or_v[gi]  = bus.op_a[gi] | bus.op_b[gi];
    assign nor_v[gi] = ~(bus.op_a[gi] | bus.op_b[gi]);
  end

  assign sum     = bus.op_a + bus.op_b;
  assign diff    = bus.op_a - bus.op_b;
  assign slt_bit = $signed(bus.op_a) < $signed(bus.op_b);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    case (bus.alu_ctrl)
      ALU_AND: alu_res = and_v;
      ALU_OR:  alu_res = or_v;
      ALU_NOR: alu_res = nor_v;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.op_a[MSB] == bus.op_b[MSB]) && (sum[MSB] != bus.op_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.op_a[MSB] != bus.op_b[MSB]) && (diff[MSB] != bus.op_a[MSB]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_MUL: begin
        if (MUL_EN) begin
          is_mul = 1'b1;
        end else begin
          alu_err = 1'b1;
        end
      end
      default: alu_err = 1'b1;
    endcase
  end

  assign accept    = bus.in_valid && in_ready_reg;
  assign mul_start = accept && is_mul;

  if (MUL_EN) begin : g_mul
    alu_seq_mul #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (mul_start),
      .mcand_in (bus.op_a),
      .mplier_in(bus.op_b),
      .busy     (mul_busy),
      .done     (mul_done),
      .product  (mul_product)
    );
  end else begin : g_no_mul
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

  // in_ready is a registered copy of (state == IDLE), except that it stays
  // low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            in_ready_reg <= 1'b0;
            if (is_mul) begin
              state_reg <= ST_MUL;
            end else begin
              state_reg     <= ST_DONE;
              result_reg    <= alu_res;
              zero_reg      <= (alu_res == '0);
              ovf_reg       <= alu_ovf;
              err_reg       <= alu_err;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_reg     <= ST_DONE;
            result_reg    <= mul_product;
            zero_reg      <= (mul_product == '0);
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
          end else if (!mul_busy) begin
            // Multiplier went idle without finishing: nothing to wait for.
            state_reg    <= ST_IDLE;
            in_ready_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Scoreboard bench: each request pushes its expected response onto exp_q,
//   each produced response pops and compares. A second instance with
//   MUL_EN=0 covers the disabled-multiply code path.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();
  alu_exec_unit_if #(.WIDTH(W)) bus0 ();

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  // Reference model, written from the operation definitions.
  function automatic exp_t model(input logic [3:0] ctrl, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit mul_en);
    exp_t e;
    logic signed [W:0] wide;
    e = '0;
    case (ctrl)
      ALU_AND: e.result = a & b;
      ALU_OR:  e.result = a | b;
      ALU_NOR: e.result = ~(a | b);
      ALU_ADD: begin
        wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
        e.result = wide[W-1:0];
        e.ovf = (wide[W] != wide[W-1]);
      end
      ALU_SUB: begin
        wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
        e.result = wide[W-1:0];
        e.ovf = (wide[W] != wide[W-1]);
      end
      ALU_SLT: e.result = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      ALU_MUL: begin
        if (mul_en) e.result = a * b;
        else e.err = 1'b1;
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Drive one request on bus; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_ready_timeout got in_ready=%b want 1", bus.in_ready);
    end
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(c, a, b, 1'b1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = $urandom();
    bus.op_a     = $urandom();
    bus.op_b     = $urandom();
  endtask

  // Wait for out_valid; lat=1 means visible right after the accepting edge.
  task automatic wait_out(output int lat, output bit ready_seen);
    lat = 1;
    ready_seen = bus.in_ready;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.in_ready) ready_seen = 1'b1;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got out_valid=%b want 1", bus.out_valid);
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_ctrl = '0; bus.op_a = '0; bus.op_b = '0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    bus0.alu_ctrl = '0; bus0.op_a = '0; bus0.op_b = '0;
    #22;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.ovf, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%b res=%h z=%b o=%b e=%b want all 0",
               bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.ovf, bus.err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_ready got %b want 1", bus.in_ready);
    end
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_add_ovf();
    int lat; bit rs; exp_t e;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL add_latency got %0d want 1", lat);
    end
    checks++;
    if ({bus.result, bus.zero, bus.ovf, bus.err} !== e) begin
      errors++;
      $display("FAIL add_ovf got %h/%b%b%b want %h/%b%b%b", bus.result, bus.zero, bus.ovf,
               bus.err, e.result, e.zero, e.ovf, e.err);
    end
    $display("ADD 7fffffff+1: result=%h ovf=%b lat=%0d", bus.result, bus.ovf, lat);
    consume();
  endtask

  task automatic test_sub_slt();
    int lat; bit rs; exp_t e;
    issue(ALU_SUB, 32'd5, 32'd5);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    checks++;
    if ({bus.result, bus.zero, bus.ovf, bus.err} !== e) begin
      errors++;
      $display("FAIL sub_zero got %h/%b%b%b want %h/%b%b%b", bus.result, bus.zero, bus.ovf,
               bus.err, e.result, e.zero, e.ovf, e.err);
    end
    $display("SUB 5-5: result=%h zero=%b", bus.result, bus.zero);
    consume();
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h0);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    checks++;
    if ({bus.result, bus.zero, bus.ovf, bus.err} !== e) begin
      errors++;
      $display("FAIL slt_signed got %h/%b%b%b want %h/%b%b%b", bus.result, bus.zero, bus.ovf,
               bus.err, e.result, e.zero, e.ovf, e.err);
    end
    $display("SLT -1<0: result=%h", bus.result);
    consume();
  endtask

  task automatic test_mul();
    int lat; bit rs; exp_t e;
    issue(ALU_MUL, 32'd1234, 32'd5678);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL mul_latency got %0d want %0d", lat, W + 1);
    end
    checks++;
    if (rs !== 1'b0) begin
      errors++;
      $display("FAIL mul_in_ready got seen=%b want 0", rs);
    end
    checks++;
    if ({bus.result, bus.zero, bus.ovf, bus.err} !== e) begin
      errors++;
      $display("FAIL mul_result got %0d/%b%b%b want %0d/%b%b%b", bus.result, bus.zero,
               bus.ovf, bus.err, e.result, e.zero, e.ovf, e.err);
    end
    $display("MUL 1234*5678: result=%0d lat=%0d", bus.result, lat);
    consume();
  endtask

  task automatic test_illegal();
    int lat; bit rs; exp_t e;
    issue(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    checks++;
    if ({bus.result, bus.zero, bus.ovf, bus.err} !== e) begin
      errors++;
      $display("FAIL illegal_code got %h/%b%b%b want %h/%b%b%b", bus.result, bus.zero,
               bus.ovf, bus.err, e.result, e.zero, e.ovf, e.err);
    end
    $display("ILLEGAL 0011: result=%h err=%b zero=%b", bus.result, bus.err, bus.zero);
    consume();
  endtask

  task automatic test_mul_disabled();
    exp_t e;
    int n = 0;
    while (!bus0.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus0.alu_ctrl = ALU_MUL;
    bus0.op_a = 32'd3;
    bus0.op_b = 32'd4;
    bus0.in_valid = 1'b1;
    exp_q.push_back(model(ALU_MUL, 32'd3, 32'd4, 1'b0));
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({bus0.out_valid, bus0.result, bus0.zero, bus0.ovf, bus0.err} !== {1'b1, e}) begin
      errors++;
      $display("FAIL mul_disabled got v=%b %h/%b%b%b want v=1 %h/%b%b%b", bus0.out_valid,
               bus0.result, bus0.zero, bus0.ovf, bus0.err, e.result, e.zero, e.ovf, e.err);
    end
    $display("MUL_EN=0 code 1000: out_valid=%b err=%b", bus0.out_valid, bus0.err);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; bit rs; exp_t e;
    issue(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.alu_ctrl = ALU_OR;
      end
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.ovf, bus.err}
          !== {2'b10, e}) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b r=%b %h want v=1 r=0 %h", i, bus.out_valid,
                 bus.in_ready, bus.result, e.result);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    $display("AND backpressure: result=%h held", bus.result);
    consume();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release_idle got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit rs; exp_t e;
    issue(ALU_MUL, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.ovf, bus.err} !== '0) begin
      errors++;
      $display("FAIL async_reset_mid_mul got v=%b r=%b res=%h want all 0", bus.out_valid,
               bus.in_ready, bus.result);
    end
    $display("reset mid-MUL: out_valid=%b result=%h", bus.out_valid, bus.result);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(ALU_NOR, 32'h0, 32'h0);
    wait_out(lat, rs);
    e = exp_q.pop_front();
    checks++;
    if ({bus.result, bus.zero, bus.ovf, bus.err} !== e) begin
      errors++;
      $display("FAIL nor_after_reset got %h want %h", bus.result, e.result);
    end
    $display("NOR 0,0 after reset: result=%h", bus.result);
    consume();
    rs = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) rs = 1'b1;
    end
    checks++;
    if (rs !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_mul_output got out_valid seen=%b want 0", rs);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [8];
    logic [3:0] c;
    logic [W-1:0] a, b;
    int lat; bit rs; exp_t e;
    codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, 4'b1111};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      c = codes[$urandom_range(0, 7)];
      a = (i % 3 == 0) ? 32'h8000_0000 : W'($urandom());
      b = (i % 4 == 1) ? 32'h7FFF_FFFF : W'($urandom());
      issue(c, a, b);
      wait_out(lat, rs);
      e = exp_q.pop_front();
      checks++;
      if ({bus.result, bus.zero, bus.ovf, bus.err} !== e || lat != ((c == ALU_MUL) ? W + 1 : 1)) begin
        errors++;
        $display("FAIL b2b_%0d ctrl=%b got %h/%b%b%b lat=%0d want %h/%b%b%b", i, c,
                 bus.result, bus.zero, bus.ovf, bus.err, lat, e.result, e.zero, e.ovf, e.err);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_in_done got %b want 0", bus.in_ready);
      end
      $display("op %0d ctrl=%b a=%h b=%h -> result=%h z=%b o=%b e=%b lat=%0d", i, c, a, b,
               bus.result, bus.zero, bus.ovf, bus.err, lat);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_slt();
    test_mul();
    test_illegal();
    test_mul_disabled();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
